// File: rtl/divider_pkg.sv
// Shared types for the iterative divider.
// div_state_t : controller states used by iter_divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One iteration of a radix-2 restoring divider (purely combinational).
// Ports:
//   part_rem  - partial remainder entering this iteration (WIDTH+1 bits)
//   next_bit  - next dividend bit shifted into the remainder
//   divisor   - magnitude of the divisor
//   new_rem   - partial remainder leaving this iteration
//   q_bit     - quotient bit produced by this iteration
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   new_rem,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {part_rem, next_bit};
    trial   = shifted - {2'b00, divisor};
    // A clear sign bit means the divisor fit: keep the difference.
    q_bit   = ~trial[WIDTH+1];
    new_rem = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider, one quotient bit per clock.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - operation request handshake
//   signed_mode           - 1 = two's-complement operands, 0 = unsigned
//   dividend, divisor     - operands (WIDTH bits)
//   out_valid / out_ready - result handshake; results held while stalled
//   quotient, remainder   - results (WIDTH bits)
//   div_by_zero, overflow - divisor was zero / signed MIN / -1
module iter_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] value,
                                               input logic             sgn);
    return (sgn && value[WIDTH-1]) ? -value : value;
  endfunction

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_r;
  // Holds the dividend magnitude; quotient bits shift in from the bottom as
  // dividend bits leave from the top, so after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] dsr_r;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (rem_r),
    .next_bit (work_r[WIDTH-1]),
    .divisor  (dsr_r),
    .new_rem  (step_rem),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      rem_r       <= '0;
      work_r      <= '0;
      dsr_r       <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready    <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else if (signed_mode && dividend == MIN_VAL && divisor == '1) begin
              quotient  <= MIN_VAL;
              remainder <= '0;
              overflow  <= 1'b1;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              work_r <= abs_val(dividend, signed_mode);
              dsr_r  <= abs_val(divisor, signed_mode);
              q_neg  <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg  <= signed_mode & dividend[WIDTH-1];
              rem_r  <= '0;
              cnt    <= CNT_W'(WIDTH);
              state  <= CALC;
            end
          end
        end
        CALC: begin
          rem_r  <= step_rem;
          work_r <= {work_r[WIDTH-2:0], step_q};
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient  <= q_neg ? -work_r : work_r;
          remainder <= r_neg ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (WIDTH = 16): expected results are
// queued at accept time and compared when the divider presents them.
module tb_iter_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int unsigned  lat;
    int unsigned  acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   holding = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sd;
    sa   = a;
    sd   = b;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.acc = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else if (sm && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = '0; e.ov = 1'b1; e.lat = 1;
    end else if (sm) begin
      e.q = sa / sd; e.r = sa % sd; e.lat = W + 2;
    end else begin
      e.q = a / b; e.r = a % b; e.lat = W + 2;
    end
    return e;
  endfunction

  // Stimulus changes at posedge+1; the monitor samples on the negedge.
  task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n = 0;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    in_valid    = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      e     = model(sm, a, b);
      e.acc = cyc;
      sb.push_back(e);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check_val("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      check_val("in_ready_busy", 32'(in_ready), 32'd0);
      if (!holding) begin
        if (sb.size() == 0) begin
          check_val("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          cur = sb.pop_front();
          check_val("latency", cyc - cur.acc + 1, cur.lat);
          holding = 1'b1;
        end
      end
      if (holding) begin
        check_val("quotient",    32'(quotient),    32'(cur.q));
        check_val("remainder",   32'(remainder),   32'(cur.r));
        check_val("div_by_zero", 32'(div_by_zero), 32'(cur.dz));
        check_val("overflow",    32'(overflow),    32'(cur.ov));
        if (out_ready) holding = 1'b0;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"},  32'(in_ready),    32'd1);
    check_val({tag, "_out_valid"}, 32'(out_valid),   32'd0);
    check_val({tag, "_quotient"},  32'(quotient),    32'd0);
    check_val({tag, "_remainder"}, 32'(remainder),   32'd0);
    check_val({tag, "_dz"},        32'(div_by_zero), 32'd0);
    check_val({tag, "_ov"},        32'(overflow),    32'd0);
  endtask

  typedef struct { logic sm; logic [W-1:0] a; logic [W-1:0] b; } op_t;
  op_t directed[$] = '{
    '{1'b0, 16'd100,   16'd7},
    '{1'b1, 16'hFF9C,  16'h0007},
    '{1'b1, 16'd100,   16'hFFF9},
    '{1'b0, 16'd1234,  16'd0},
    '{1'b1, 16'd1234,  16'd0},
    '{1'b1, 16'h8000,  16'hFFFF},
    '{1'b0, 16'h8000,  16'hFFFF},
    '{1'b1, 16'h8000,  16'h0001},
    '{1'b0, 16'hFFFF,  16'h0001},
    '{1'b1, 16'h7FFF,  16'hFFFF}
  };

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (directed[i]) begin
      do_op(directed[i].sm, directed[i].a, directed[i].b);
      wait_idle();
    end

    for (int i = 0; i < 24; i++) begin
      logic         sm;
      logic [W-1:0] a;
      logic [W-1:0] b;
      sm = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      b  = W'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 5) == 0) b = W'($urandom_range(1, 9));
      do_op(sm, a, b);
      wait_idle();
    end

    // Back-pressure: result stalled for 5 cycles while a new request waits.
    out_ready = 1'b0;
    do_op(1'b0, 16'd1000, 16'd33);
    signed_mode = 1'b1;
    dividend    = 16'hA2D0;
    divisor     = 16'd123;
    in_valid    = 1'b1;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) check_val("bp_wait_timeout", 32'(out_valid), 32'd1);
    end
    repeat (5) begin
      @(posedge clk); #1;
      check_val("bp_out_valid_held", 32'(out_valid), 32'd1);
      check_val("bp_in_ready_low",   32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_in_ready_after", 32'(in_ready),  32'd1);
    check_val("bp_out_valid_drop", 32'(out_valid), 32'd0);
    do_op(1'b1, 16'hA2D0, 16'd123);
    wait_idle();

    // Reset in the middle of CALC discards the operation.
    do_op(1'b0, 16'd50000, 16'd3);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    holding = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midcalc_reset");
    rst = 1'b0;
    do_op(1'b0, 16'd65535, 16'd255);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Parametrised multi-cycle integer divider: radix-2 restoring, one quotient bit per clock, operand width set by parameter.
- Supports signed and unsigned division, selected per operation.
- Uses a valid/ready handshake on both input and output.
- Flags divide-by-zero and signed overflow.
- Successor to the fixed 16-bit fast divider, for datapaths needing wider operands, signed mode or output back-pressure.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range >= 2.
- CNT_W, $clog2(WIDTH+1), derived localparam; iteration counter width; not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept an operation
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned
- dividend  input  WIDTH  dividend
- divisor  input  WIDTH  divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- quotient  output  WIDTH  quotient
- remainder  output  WIDTH  remainder
- div_by_zero  output  1  divisor was zero
- overflow  output  1  signed MIN / -1 case

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0.
  - quotient, remainder, div_by_zero and overflow all 0.
  - Internal registers cleared.
- States: IDLE, CALC, FIX, DONE.
- in_ready = (state == IDLE). Accept happens on a clock edge with in_valid && in_ready. signed_mode, dividend and divisor are captured on that edge.
- IDLE transitions on accept:
  - divisor == 0: go to DONE. quotient = all ones, remainder = dividend, div_by_zero = 1.
  - signed_mode && dividend == MIN && divisor == all ones: go to DONE. quotient = MIN, remainder = 0, overflow = 1.
  - otherwise: go to CALC. Store |dividend| and |divisor| (absolute values only when signed_mode). Store result signs: quotient negative = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). Clear the partial remainder and load counter = WIDTH.
- CALC:
  - Each cycle: shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the partial remainder in WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. When it reaches 0, go to FIX. CALC lasts exactly WIDTH cycles.
- FIX: negate quotient and/or remainder as required by the stored signs (signed mode only), then go to DONE. FIX lasts 1 cycle.
- DONE:
  - out_valid = 1. All result outputs and flags are held stable while out_ready = 0.
  - On out_valid && out_ready: go to IDLE; out_valid drops on that edge.
  - Flags remain valid only while out_valid = 1; they are cleared on the next accept.
- Latency, accept edge to out_valid high:
  - normal operation: WIDTH+2 cycles.
  - divide-by-zero or overflow: 1 cycle.
- Throughput: at most one operation in flight. in_valid is ignored outside IDLE. An input presented in the same cycle as output consumption is accepted one cycle later, after the return to IDLE.
- Arithmetic rules:
  - Signed quotient truncates toward zero.
  - Remainder has the sign of the dividend; |remainder| < |divisor|.
  - dividend = quotient*divisor + remainder modulo 2^WIDTH for all non-zero divisors.
- Reset in any state aborts the operation and restores reset values on the next edge. A result in flight is discarded.

Decomposition:
- divider_pkg:
  - div_state_t enum (IDLE, CALC, FIX, DONE).
  - Function abs_val(value, signed_mode), parametrised by width through a parameterised class-static or a WIDTH-sized local function.
- Sub-module div_step: combinational one-iteration restoring step.
  - Inputs: partial remainder (WIDTH+1), next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside iter_divider.

Test Plan (WIDTH = 16):
- Unsigned 100 / 7 -> quotient 14, remainder 2, flags 0; out_valid exactly 18 cycles after accept.
- Signed -100 / 7 (0xFF9C / 0x0007) -> quotient 0xFFF2 (-14), remainder 0xFFFE (-2); also run 100 / -7 -> quotient 0xFFF2, remainder 0x0002.
- 1234 / 0, both modes -> quotient 0xFFFF, remainder 1234, div_by_zero 1; out_valid 1 cycle after accept.
- 0x8000 / 0xFFFF:
  - signed -> quotient 0x8000, remainder 0, overflow 1, 1-cycle latency.
  - unsigned -> quotient 0, remainder 0x8000, overflow 0, 18-cycle latency.
- Back-pressure: hold out_ready = 0 for 5 cycles in DONE while driving in_valid with new operands. Required: outputs stable, in_ready 0, new operation not accepted. After out_ready pulse: in_ready 1 next cycle, second operation then completes correctly.
- Assert rst during CALC cycle 8 -> next cycle out_valid 0, in_ready 1, outputs 0. A following 65535 / 255 (unsigned) returns quotient 257, remainder 0.
